// File: rtl/i2c_reg_sequencer_pkg.sv
// i2c_reg_sequencer_pkg
// Shared I2C constants for the register sequencer: engine command codes,
// sequencer state codes and small helpers that map a sequencer state to
// the command/byte it presents to the byte engine.
package i2c_reg_sequencer_pkg;

  // Commands understood by the I2C byte engine.
  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_START     = 3'd1,
    CMD_RESTART   = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_READ_ACK  = 3'd4,
    CMD_READ_NACK = 3'd5,
    CMD_STOP      = 3'd6
  } eng_cmd_e;

  // Sequencer states; every state between IDLE and FIN issues one command.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_DEVW   = 4'd2,
    ST_REG    = 4'd3,
    ST_DATA   = 4'd4,
    ST_RSTART = 4'd5,
    ST_DEVR   = 4'd6,
    ST_READ   = 4'd7,
    ST_STOP   = 4'd8,
    ST_FIN    = 4'd9
  } seq_state_e;

  localparam logic ADDR_WR = 1'b0;
  localparam logic ADDR_RD = 1'b1;

  // Address byte on the wire: 7-bit slave address followed by the R/W bit.
  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rd);
    return {dev, rd};
  endfunction

  // Engine command presented while the sequencer sits in a given state.
  function automatic eng_cmd_e state_cmd(input seq_state_e st);
    eng_cmd_e c;
    case (st)
      ST_START:  c = CMD_START;
      ST_DEVW:   c = CMD_WRITE;
      ST_REG:    c = CMD_WRITE;
      ST_DATA:   c = CMD_WRITE;
      ST_RSTART: c = CMD_RESTART;
      ST_DEVR:   c = CMD_WRITE;
      ST_READ:   c = CMD_READ_NACK;
      ST_STOP:   c = CMD_STOP;
      default:   c = CMD_NOP;
    endcase
    return c;
  endfunction

  // Byte presented on eng_tx in a given state; zero for non-WRITE commands.
  function automatic logic [7:0] state_tx(input seq_state_e st, input logic [6:0] dev,
                                          input logic [7:0] regad, input logic [7:0] wdat);
    logic [7:0] b;
    case (st)
      ST_DEVW: b = addr_byte(dev, ADDR_WR);
      ST_REG:  b = regad;
      ST_DATA: b = wdat;
      ST_DEVR: b = addr_byte(dev, ADDR_RD);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // States whose command is a WRITE and therefore reports a slave ACK/NACK.
  function automatic logic is_write_state(input seq_state_e st);
    logic w;
    case (st)
      ST_DEVW, ST_REG, ST_DATA, ST_DEVR: w = 1'b1;
      default:                          w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/i2c_reg_sequencer_rr.sv
// i2c_rr_arbiter
// Two-requester round-robin arbiter with a registered one-hot grant.
// Ports:
//   clk, reset  - clock, synchronous active-low reset
//   req[1:0]    - request levels
//   take        - sample pick into gnt this cycle (sequencer idle)
//   clear       - drop gnt this cycle (transaction finished)
//   pick[1:0]   - combinational winner for the current requests
//   gnt[1:0]    - registered one-hot grant
module i2c_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  input  logic       clear,
  output logic [1:0] pick,
  output logic [1:0] gnt
);

  // Index of the requester served most recently; 1 after reset so that
  // requester 0 wins the first tie.
  logic last_r;

  // Winner selection: a lone request wins, a tie goes to the one not served last.
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_r ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  // Grant and last-served registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt    <= 2'b00;
      last_r <= 1'b1;
    end else if (clear) begin
      gnt    <= 2'b00;
    end else if (take && (pick != 2'b00)) begin
      gnt    <= pick;
      last_r <= pick[1];
    end
  end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
// Arbitrates two register-access requesters and sequences one I2C register
// read or write per grant through a byte-level I2C engine.
// Ports:
//   clk, reset              - clock, synchronous active-low reset
//   req/rw/dev/reg/wdat 0,1 - requester transaction (level request held until done)
//   gnt[1:0]                - one-hot grant, stable for the whole transaction
//   done[1:0], err          - one-cycle completion pulse per requester, err with it
//   rdata[7:0]              - last read result
//   eng_cmd/eng_valid/eng_tx- command to the byte engine
//   eng_done/eng_rx/eng_ack - engine completion pulse, read byte, ACK (0=ACK)
module i2c_reg_sequencer
  import i2c_reg_sequencer_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [6:0] dev0,
  input  logic [6:0] dev1,
  input  logic [7:0] reg0,
  input  logic [7:0] reg1,
  input  logic [7:0] wdat0,
  input  logic [7:0] wdat1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic       err,
  output logic [2:0] eng_cmd,
  output logic       eng_valid,
  output logic [7:0] eng_tx,
  input  logic       eng_done,
  input  logic [7:0] eng_rx,
  input  logic       eng_ack
);

  seq_state_e  state_r;
  seq_state_e  next_s;
  logic        rw_r;
  logic [6:0]  dev_r;
  logic [7:0]  regad_r;
  logic [7:0]  wdat_r;
  logic        err_flag_r;
  logic [15:0] timer_r;
  logic [1:0]  pick_s;
  logic        take_s;
  logic        clear_s;

  assign take_s  = (state_r == ST_IDLE);
  assign clear_s = (state_r == ST_FIN);

  i2c_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1, req0}),
    .take  (take_s),
    .clear (clear_s),
    .pick  (pick_s),
    .gnt   (gnt)
  );

  // Successor of a command state after a successful (ACKed) completion.
  always_comb begin
    next_s = ST_IDLE;
    case (state_r)
      ST_START:  next_s = ST_DEVW;
      ST_DEVW:   next_s = ST_REG;
      ST_REG:    next_s = rw_r ? ST_RSTART : ST_DATA;
      ST_DATA:   next_s = ST_STOP;
      ST_RSTART: next_s = ST_DEVR;
      ST_DEVR:   next_s = ST_READ;
      ST_READ:   next_s = ST_STOP;
      ST_STOP:   next_s = ST_FIN;
      default:   next_s = ST_IDLE;
    endcase
  end

  // Sequencer FSM with registered engine interface and completion outputs.
  // eng_cmd/eng_tx are loaded on the edge that enters a state, so they are
  // stable across the one idle (eng_valid=0) cycle that opens every state
  // and for the whole time eng_valid is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      rw_r       <= 1'b0;
      dev_r      <= 7'h00;
      regad_r    <= 8'h00;
      wdat_r     <= 8'h00;
      err_flag_r <= 1'b0;
      timer_r    <= 16'd0;
      done       <= 2'b00;
      err        <= 1'b0;
      rdata      <= 8'h00;
      eng_valid  <= 1'b0;
      eng_cmd    <= CMD_NOP;
      eng_tx     <= 8'h00;
    end else begin
      done <= 2'b00;
      err  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_s != 2'b00) begin
            rw_r       <= pick_s[1] ? rw1   : rw0;
            dev_r      <= pick_s[1] ? dev1  : dev0;
            regad_r    <= pick_s[1] ? reg1  : reg0;
            wdat_r     <= pick_s[1] ? wdat1 : wdat0;
            err_flag_r <= 1'b0;
            state_r    <= ST_START;
            eng_cmd    <= CMD_START;
            eng_tx     <= 8'h00;
          end
        end
        ST_FIN: begin
          state_r <= ST_IDLE;
        end
        default: begin
          if (!eng_valid) begin
            // Opening gap cycle of the state: raise the command.
            eng_valid <= 1'b1;
            timer_r   <= 16'd0;
          end else if (eng_done) begin
            eng_valid <= 1'b0;
            timer_r   <= 16'd0;
            if (is_write_state(state_r) && eng_ack) begin
              // NACKed byte: skip the remaining bytes and close the bus.
              err_flag_r <= 1'b1;
              state_r    <= ST_STOP;
              eng_cmd    <= state_cmd(ST_STOP);
              eng_tx     <= 8'h00;
            end else begin
              if (state_r == ST_READ) begin
                rdata <= eng_rx;
              end
              if (state_r == ST_STOP) begin
                done <= gnt;
                err  <= err_flag_r;
              end
              state_r <= next_s;
              eng_cmd <= state_cmd(next_s);
              eng_tx  <= state_tx(next_s, dev_r, regad_r, wdat_r);
            end
          end else if (timer_r == (TIMEOUT - 16'd1)) begin
            // Engine hung: abandon the transaction without a STOP.
            eng_valid  <= 1'b0;
            timer_r    <= 16'd0;
            err_flag_r <= 1'b1;
            state_r    <= ST_FIN;
            eng_cmd    <= CMD_NOP;
            eng_tx     <= 8'h00;
            done       <= gnt;
            err        <= 1'b1;
          end else begin
            timer_r <= timer_r + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer
// Scoreboard bench: directed transactions push expected engine commands and
// completion results into queues; a monitor pops and compares them whenever
// the DUT raises a new command or a done pulse. A behavioural engine answers
// each command after a short delay, with optional NACK or silence.
module tb_i2c_reg_sequencer;
  import i2c_reg_sequencer_pkg::*;

  logic       clk;
  logic       reset;
  logic       req0, req1, rw0, rw1;
  logic [6:0] dev0, dev1;
  logic [7:0] reg0, reg1, wdat0, wdat1;
  logic [1:0] gnt, done;
  logic [7:0] rdata;
  logic       err;
  logic [2:0] eng_cmd;
  logic       eng_valid;
  logic [7:0] eng_tx;
  logic       eng_done;
  logic [7:0] eng_rx;
  logic       eng_ack;

  i2c_reg_sequencer #(.TIMEOUT(16'd20)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .dev0(dev0), .dev1(dev1), .reg0(reg0), .reg1(reg1),
    .wdat0(wdat0), .wdat1(wdat1),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .eng_cmd(eng_cmd), .eng_valid(eng_valid), .eng_tx(eng_tx),
    .eng_done(eng_done), .eng_rx(eng_rx), .eng_ack(eng_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [2:0] cmd; logic [7:0] tx; logic chk_tx; } cmd_t;
  typedef struct { logic [1:0] done; logic err; logic chk_rd; logic [7:0] rdata; } res_t;

  cmd_t exp_cmds[$];
  res_t exp_res[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // engine model controls
  logic       silent;
  int         nack_at;
  int         cmd_idx;
  logic [7:0] rx_val;
  int         last_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [2:0] c, input logic [7:0] tx);
    cmd_t e;
    e.cmd = c; e.tx = tx; e.chk_tx = (c == CMD_WRITE);
    exp_cmds.push_back(e);
  endtask

  task automatic push_res(input logic [1:0] d, input logic e, input logic chk, input logic [7:0] rd);
    res_t r;
    r.done = d; r.err = e; r.chk_rd = chk; r.rdata = rd;
    exp_res.push_back(r);
  endtask

  // addr byte is hand-computed {dev,0}
  task automatic exp_write(input logic [7:0] a, input logic [7:0] r, input logic [7:0] d);
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, a); push_cmd(CMD_WRITE, r);
    push_cmd(CMD_WRITE, d); push_cmd(CMD_STOP, 8'h00);
  endtask

  task automatic exp_read(input logic [7:0] aw, input logic [7:0] r, input logic [7:0] ar);
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, aw); push_cmd(CMD_WRITE, r);
    push_cmd(CMD_RESTART, 8'h00); push_cmd(CMD_WRITE, ar); push_cmd(CMD_READ_NACK, 8'h00);
    push_cmd(CMD_STOP, 8'h00);
  endtask

  task automatic wait_gnt(input logic [1:0] g, input string name);
    int n = 0;
    while (gnt == 2'b00 && n < 500) begin @(negedge clk); n++; end
    check(name, {30'd0, gnt}, {30'd0, g});
  endtask

  task automatic wait_done(input int idx, input string name);
    int n = 0;
    while (done[idx] !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    check(name, {31'd0, done[idx]}, 32'd1);
  endtask

  // behavioural byte engine: answers each command on its third valid cycle
  initial begin
    int wait_cnt = 0;
    eng_done = 1'b0; eng_ack = 1'b0; eng_rx = 8'h00;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      eng_ack  = 1'b0;
      eng_rx   = rx_val;
      if (eng_valid === 1'b1 && !silent) begin
        if (wait_cnt == 2) begin
          eng_done = 1'b1;
          eng_ack  = (cmd_idx == nack_at);
          cmd_idx++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // monitor: compare each new command and each done pulse with the queues
  initial begin
    logic prev_valid = 1'b0;
    int   run_len = 0;
    cmd_t e;
    res_t r;
    last_run = 0;
    forever begin
      @(negedge clk);
      if (eng_valid === 1'b1 && !prev_valid) begin
        if (exp_cmds.size() == 0) begin
          check("cmd_expected_pending", 32'd0, 32'd1);
        end else begin
          e = exp_cmds.pop_front();
          check("eng_cmd", {29'd0, eng_cmd}, {29'd0, e.cmd});
          if (e.chk_tx) check("eng_tx", {24'd0, eng_tx}, {24'd0, e.tx});
        end
      end
      if (done !== 2'b00 && reset === 1'b1) begin
        if (exp_res.size() == 0) begin
          check("done_expected_pending", 32'd0, 32'd1);
        end else begin
          r = exp_res.pop_front();
          check("done", {30'd0, done}, {30'd0, r.done});
          check("err", {31'd0, err}, {31'd0, r.err});
          if (r.chk_rd) check("rdata", {24'd0, rdata}, {24'd0, r.rdata});
        end
      end
      if (eng_valid === 1'b1) begin
        run_len++;
      end else if (prev_valid) begin
        last_run = run_len;
        run_len  = 0;
      end
      prev_valid = (eng_valid === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},       {30'd0, gnt},       32'd0);
    check({tag, "_done"},      {30'd0, done},      32'd0);
    check({tag, "_err"},       {31'd0, err},       32'd0);
    check({tag, "_rdata"},     {24'd0, rdata},     32'd0);
    check({tag, "_eng_valid"}, {31'd0, eng_valid}, 32'd0);
    check({tag, "_eng_cmd"},   {29'd0, eng_cmd},   32'd0);
    check({tag, "_eng_tx"},    {24'd0, eng_tx},    32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    dev0 = 7'h00; dev1 = 7'h00; reg0 = 8'h00; reg1 = 8'h00; wdat0 = 8'h00; wdat1 = 8'h00;
    silent = 1'b0; nack_at = -1; cmd_idx = 0; rx_val = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // T1: simultaneous requests after reset; req0 write, then req1 read
    exp_write(8'hA0, 8'h10, 8'hA5);
    exp_read(8'hD0, 8'h75, 8'hD1);
    push_res(2'b01, 1'b0, 1'b0, 8'h00);
    push_res(2'b10, 1'b0, 1'b1, 8'h71);
    rx_val = 8'h71;
    rw0 = 1'b0; dev0 = 7'h50; reg0 = 8'h10; wdat0 = 8'hA5;
    rw1 = 1'b1; dev1 = 7'h68; reg1 = 8'h75; wdat1 = 8'hEE;
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(2'b01, "t1_gnt_first");
    dev0 = 7'h11; reg0 = 8'h22; wdat0 = 8'h33; rw0 = 1'b1;   // must be ignored
    wait_done(0, "t1_done0");
    check("t1_gnt_in_done_cycle", {30'd0, gnt}, 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    check("t1_gnt_cleared", {30'd0, gnt}, 32'd0);
    @(negedge clk);
    check("t1_gnt_second", {30'd0, gnt}, 32'd2);
    wait_done(1, "t1_done1");
    req1 = 1'b0;
    @(negedge clk);

    // T2: req1 write dev 0x3C; rdata keeps the earlier read value
    exp_write(8'h78, 8'h02, 8'h5A);
    push_res(2'b10, 1'b0, 1'b1, 8'h71);
    rw1 = 1'b0; dev1 = 7'h3C; reg1 = 8'h02; wdat1 = 8'h5A;
    req1 = 1'b1;
    wait_gnt(2'b10, "t2_gnt");
    wait_done(1, "t2_done");
    req1 = 1'b0;
    @(negedge clk);

    // T3: req0 read dev 0x1F reg 0xFF, request dropped right after grant
    exp_read(8'h3E, 8'hFF, 8'h3F);
    push_res(2'b01, 1'b0, 1'b1, 8'hC3);
    rx_val = 8'hC3;
    rw0 = 1'b1; dev0 = 7'h1F; reg0 = 8'hFF; wdat0 = 8'h00;
    req0 = 1'b1;
    wait_gnt(2'b01, "t3_gnt");
    req0 = 1'b0;
    wait_done(0, "t3_done");
    @(negedge clk);

    // T4: address byte NACKed -> straight to STOP, err set
    cmd_idx = 0; nack_at = 1;
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'hA0); push_cmd(CMD_STOP, 8'h00);
    push_res(2'b01, 1'b1, 1'b1, 8'hC3);
    rw0 = 1'b0; dev0 = 7'h50; reg0 = 8'h10; wdat0 = 8'hA5;
    req0 = 1'b1;
    wait_gnt(2'b01, "t4_gnt");
    wait_done(0, "t4_done");
    req0 = 1'b0;
    @(negedge clk);
    nack_at = -1;

    // T5: engine never answers -> eng_valid high 20 cycles, err, no STOP
    silent = 1'b1;
    push_cmd(CMD_START, 8'h00);
    push_res(2'b10, 1'b1, 1'b1, 8'hC3);
    rw1 = 1'b0; dev1 = 7'h3C; reg1 = 8'h02; wdat1 = 8'h5A;
    req1 = 1'b1;
    wait_gnt(2'b10, "t5_gnt");
    wait_done(1, "t5_done");
    req1 = 1'b0;
    @(negedge clk);
    check("t5_valid_cycles", last_run, 32'd20);
    silent = 1'b0;
    repeat (3) @(negedge clk);

    // T6: reset while the register byte is on the engine
    cmd_idx = 0;
    push_cmd(CMD_START, 8'h00); push_cmd(CMD_WRITE, 8'hA0); push_cmd(CMD_WRITE, 8'h10);
    rw0 = 1'b0; dev0 = 7'h50; reg0 = 8'h10; wdat0 = 8'hA5;
    req0 = 1'b1;
    n = 0;
    while (!(eng_valid === 1'b1 && eng_cmd == CMD_WRITE && eng_tx == 8'h10) && n < 500) begin
      @(negedge clk); n++;
    end
    check("t6_reached_reg", {31'd0, eng_valid}, 32'd1);
    reset = 1'b0; req0 = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6_reset");
    reset = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 2'b00 || eng_valid !== 1'b0) seen = 1'b1;
    end
    check("t6_quiet_after_reset", {31'd0, seen}, 32'd0);

    check("cmd_queue_drained", exp_cmds.size(), 32'd0);
    check("res_queue_drained", exp_res.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_sequencer.md
I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 16'd50000, clk cycles allowed per engine command before abort.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports: req0/req1  input  1 each  requester transaction request, level, held until done.
REQ-005 SHALL have ports: rw0/rw1  input  1 each  1=register read, 0=register write.
REQ-006 SHALL have ports: dev0/dev1  input  7 each  7-bit slave address.
REQ-007 SHALL have ports: reg0/reg1  input  8 each  register address; wdat0/wdat1  input  8 each  write data.
REQ-008 SHALL have ports: gnt  output  2  one-hot grant; done  output  2  one-cycle completion pulse per requester.
REQ-009 SHALL have ports: rdata  output  8  read result; err  output  1  valid with done, 1=NACK or timeout.
REQ-010 SHALL have ports: eng_cmd  output  3  engine command; eng_valid  output  1; eng_tx  output  8  byte to send.
REQ-011 SHALL have ports: eng_done  input  1  one-cycle command-complete pulse; eng_rx  input  8; eng_ack  input  1  0=slave ACKed.

Function
REQ-012 SHALL arbitrate round-robin: in IDLE, if exactly one req set grant it; if both, grant the one not served last; after reset requester 0 has priority.
REQ-013 SHALL latch rw/dev/reg/wdat of the granted requester in the grant cycle; later input changes ignored until done.
REQ-014 SHALL sequence states IDLE->START->DEVW->REG->(write: DATA->STOP; read: RSTART->DEVR->READ->STOP)->FIN->IDLE.
REQ-015 SHALL issue commands: START, WRITE(dev,0), WRITE(reg), WRITE(wdat) | RESTART, WRITE(dev,1), READ_NACK, then STOP.
REQ-016 SHALL hold eng_valid=1 with stable eng_cmd/eng_tx from state entry until the cycle eng_done=1; advance on the next edge.
REQ-017 SHALL drop eng_valid for at least one cycle between consecutive commands.
REQ-018 SHALL on eng_done after any WRITE with eng_ack=1 set error flag and jump directly to STOP (no further bytes).
REQ-019 SHALL capture eng_rx into rdata on eng_done of READ_NACK; rdata otherwise retains last value.
REQ-020 SHALL count cycles per command; on reaching TIMEOUT without eng_done set error, deassert eng_valid, go to FIN without STOP.
REQ-021 SHALL in FIN pulse done[granted] for one cycle with err, clear gnt next cycle, return to IDLE.
REQ-022 SHALL ignore eng_done while eng_valid=0.
REQ-023 SHALL keep gnt stable for the whole transaction even if req drops; a dropped req does not abort.
REQ-024 SHALL not regrant the same requester in the cycle its done pulses; earliest new grant is the cycle after gnt clears.

Reset
REQ-025 SHALL on reset=0 at posedge: state IDLE, gnt=0, done=0, err=0, rdata=0, eng_valid=0, eng_cmd=NOP, eng_tx=0, timer=0, last-served=1.
REQ-026 SHALL on reset mid-transaction abandon it without STOP and without done pulse.

Structure
REQ-027 SHALL place engine command codes (NOP, START, RESTART, WRITE, READ_ACK, READ_NACK, STOP) and state codes in the shared I2C constants header.
REQ-028 SHALL implement arbitration as sub-module i2c_rr_arbiter (2 req in, one-hot gnt out, last-served register).

Verification
REQ-029 SHALL cover: req0 write dev=0x50 reg=0x10 wdat=0xA5, engine ACKs all -> cmds START,WR 0xA0,WR 0x10,WR 0xA5,STOP; done=01, err=0.
REQ-030 SHALL cover: req1 read dev=0x68 reg=0x75, eng_rx=0x71 -> cmds START,WR 0xD0,WR 0x75,RESTART,WR 0xD1,READ_NACK,STOP; rdata=0x71, done=10.
REQ-031 SHALL cover: req0/req1 asserted same cycle after reset -> gnt=01 first, then gnt=10; two done pulses in order.
REQ-032 SHALL cover: eng_ack=1 on WR 0xA0 -> next command STOP, no REG byte; done with err=1.
REQ-033 SHALL cover: TIMEOUT=20, eng_done never returns -> eng_valid drops at cycle 20, done with err=1, no STOP.
REQ-034 SHALL cover: reset=0 during REG command -> next cycle all outputs at reset values, no done pulse.
